piezo_tone_gen: RTL and testbench
=================================

PIEZO_TONE_GEN -- requirements
Module: piezo_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter GAP_MS, default 20, length of the inter-note silence in ms (used only with TONE_GAP_EN).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port note_code  input  4  requested note from the answer/playback stage, level-held, 0 = rest.
REQ-006 SHALL have port piezo  output  1  square-wave drive to the piezo.
REQ-007 SHALL have port active_note  output  4  note code currently sounding (0 when silent).
REQ-008 SHALL have port tone_on  output  1  high while a non-rest note is being driven.

Function
REQ-009 SHALL register note_code once before use (1-cycle input stage, req_q).
REQ-010 SHALL map codes 1..8 to C4,D4,E4,F4,G4,A4,B4,C5; codes 0 and 9..15 are rest.
REQ-011 SHALL use half-period divisor = round(CLK_HZ / (2*f_note)); counter is 17 bits (C4 at 50 MHz = 95556).
REQ-012 SHALL toggle piezo when the half-period counter reaches divisor-1, then reload the counter to 0.
REQ-013 SHALL implement states IDLE, TONE, PEND (plus GAP with TONE_GAP_EN).
REQ-014 IDLE: piezo=0, tone_on=0; on req_q non-rest -> TONE next cycle, counter=0, piezo starts low, active_note=req_q.
REQ-015 TONE: on req_q == active_note stay; on any change -> PEND.
REQ-016 PEND: keep current tone until the end of the high half-period (piezo falling edge), then adopt the latest req_q: rest -> IDLE, tone -> TONE (or GAP).
REQ-017 PEND SHALL honour only the most recent req_q at the switch instant; a return to the original code during PEND -> back to TONE with no phase disturbance.
REQ-018 piezo SHALL never produce a high pulse shorter than the current half-period (glitch-free switching).
REQ-019 active_note and tone_on SHALL change in the same cycle the new note takes effect.

Reset
REQ-020 While reset=0: state=IDLE, piezo=0, active_note=0, tone_on=0, counter=0, req_q=0.
REQ-021 Reset assertion mid-tone SHALL silence piezo immediately (asynchronous); release resumes from IDLE.

Configuration
REQ-022 Macro PIEZO_TONE_GAP_EN SHALL, when defined, add state GAP: on a tone-to-tone switch, hold piezo=0, tone_on=0, active_note=0 for CLK_HZ/1000*GAP_MS cycles, then enter TONE with the latest req_q (rest -> IDLE).
REQ-023 Without PIEZO_TONE_GAP_EN, tone-to-tone switches SHALL go directly PEND -> TONE with no silent cycles and no GAP logic present.

Structure
REQ-024 Shared package tone_pkg SHALL hold the note-code constants, the note frequency table (centi-Hz) and the divisor function.
REQ-025 Sub-module tone_divider (17-bit half-period counter + toggle flop, load/enable inputs) is natural and SHALL be used.

Verification
REQ-026 Reset held low, note_code=6 -> piezo=0, tone_on=0 throughout.
REQ-027 Release reset, note_code=6 (A4) -> tone_on=1 two cycles later; piezo period 113636 cycles, high 56818 cycles.
REQ-028 While A4 sounds, note_code=1 mid-high-half -> A4 continues to its falling edge, then C4 half-period 95556 cycles; no short pulse.
REQ-029 note_code=12 -> treated as rest: piezo=0, active_note=0.
REQ-030 A4 sounding, note_code pulses to 3 for 10 cycles then back to 6 inside the high half -> no change in piezo phase.
REQ-031 With PIEZO_TONE_GAP_EN, GAP_MS=20: switch 1 -> 8 yields exactly 1_000_000 low cycles with tone_on=0 before C5 (period 95556) begins.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the piezo tone generator: note codes, FSM state
// encoding, the note frequency table and the half-period divisor function.
package tone_pkg;

  // Note codes as presented on note_code; 0 and 9..15 are rests.
  localparam logic [3:0] NoteRest = 4'd0;
  localparam logic [3:0] NoteC4   = 4'd1;
  localparam logic [3:0] NoteD4   = 4'd2;
  localparam logic [3:0] NoteE4   = 4'd3;
  localparam logic [3:0] NoteF4   = 4'd4;
  localparam logic [3:0] NoteG4   = 4'd5;
  localparam logic [3:0] NoteA4   = 4'd6;
  localparam logic [3:0] NoteB4   = 4'd7;
  localparam logic [3:0] NoteC5   = 4'd8;

  // Half-period counter width; C4 at 50 MHz needs 95556.
  localparam int unsigned DivW = 17;
  typedef logic [DivW-1:0] div_t;

`ifdef PIEZO_TONE_GAP_EN
  typedef enum logic [1:0] {StIdle, StTone, StPend, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StTone, StPend} state_e;
`endif

  function automatic logic is_tone(logic [3:0] code);
    return (code >= NoteC4) && (code <= NoteC5);
  endfunction

  // Note frequencies in milli-Hz. Centi-Hz is too coarse for C4: 261.63 Hz
  // gives 95555 at 50 MHz, while the true pitch (261.626 Hz) gives 95556.
  function automatic int unsigned note_mhz(logic [3:0] code);
    case (code)
      NoteC4:  return 261626;
      NoteD4:  return 293665;
      NoteE4:  return 329628;
      NoteF4:  return 349228;
      NoteG4:  return 391995;
      NoteA4:  return 440000;
      NoteB4:  return 493883;
      NoteC5:  return 523251;
      default: return 0;
    endcase
  endfunction

  // round(clk_hz / (2 * f)); only ever evaluated on constants.
  function automatic div_t half_div(int unsigned clk_hz, logic [3:0] code);
    longint unsigned two_f;
    longint unsigned num;
    two_f = 64'(note_mhz(code)) * 64'd2;
    if (two_f == 64'd0) return '0;
    num = 64'(clk_hz) * 64'd1000 + two_f / 64'd2;
    return div_t'(num / two_f);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter plus toggle flop producing the piezo square wave.
// load_i forces counter=0 and output low; en_i lets the counter run.
module tone_divider
  import tone_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  input  div_t div_i,
  output logic piezo_o,
  output logic fall_o
);

  div_t cnt_q, cnt_d;
  logic out_q, out_d;
  logic wrap;

  assign wrap = (cnt_q == div_i - div_t'(1));

  // Count to divisor-1, then toggle and restart.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (load_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d = '0;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + div_t'(1);
      end
    end
  end

  // Counter and output flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  // High this cycle means the output falls at the next edge.
  assign fall_o  = en_i & out_q & wrap;
  assign piezo_o = out_q;

endmodule

// File: rtl/piezo_tone_gen.sv
// Piezo tone generator: turns a level-held note code into a square wave.
// Note changes wait for the end of the current high half-period so the
// piezo never sees a shortened pulse.
// Optional feature macro: PIEZO_TONE_GAP_EN inserts a silent gap of
// CLK_HZ/1000*GAP_MS cycles between two different notes.
module piezo_tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned GAP_MS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] note_code,
  output logic       piezo,
  output logic [3:0] active_note,
  output logic       tone_on
);

  localparam div_t DivC4 = half_div(CLK_HZ, NoteC4);
  localparam div_t DivD4 = half_div(CLK_HZ, NoteD4);
  localparam div_t DivE4 = half_div(CLK_HZ, NoteE4);
  localparam div_t DivF4 = half_div(CLK_HZ, NoteF4);
  localparam div_t DivG4 = half_div(CLK_HZ, NoteG4);
  localparam div_t DivA4 = half_div(CLK_HZ, NoteA4);
  localparam div_t DivB4 = half_div(CLK_HZ, NoteB4);
  localparam div_t DivC5 = half_div(CLK_HZ, NoteC5);

`ifdef PIEZO_TONE_GAP_EN
  localparam int unsigned GapCycles = CLK_HZ / 1000 * GAP_MS;
  localparam logic [31:0] GapLast   = (GapCycles == 0) ? 32'd0 : 32'(GapCycles - 1);
  logic [31:0] gap_cnt_q;
`endif

  state_e     state_q;
  logic [3:0] req_q;
  logic [3:0] active_q;
  logic       tone_on_q;

  div_t div;
  logic div_en;
  logic div_load;
  logic div_fall;
  logic switch_now;

  // Divisor of the note currently sounding.
  always_comb begin
    div = DivC4;
    case (active_q)
      NoteD4:  div = DivD4;
      NoteE4:  div = DivE4;
      NoteF4:  div = DivF4;
      NoteG4:  div = DivG4;
      NoteA4:  div = DivA4;
      NoteB4:  div = DivB4;
      NoteC5:  div = DivC5;
      default: div = DivC4;
    endcase
  end

  // Divider runs while a note sounds; it is parked low otherwise and
  // restarted from zero whenever a pending change takes effect.
  always_comb begin
    switch_now = (state_q == StPend) && div_fall && (req_q != active_q);
    div_en     = (state_q == StTone) || (state_q == StPend);
    div_load   = !div_en || switch_now;
  end

  tone_divider u_divider (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (div_load),
    .en_i    (div_en),
    .div_i   (div),
    .piezo_o (piezo),
    .fall_o  (div_fall)
  );

  // Input stage and note-sequencing FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      req_q     <= NoteRest;
      active_q  <= NoteRest;
      tone_on_q <= 1'b0;
`ifdef PIEZO_TONE_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      req_q <= note_code;
      unique case (state_q)
        StIdle: begin
          if (is_tone(req_q)) begin
            state_q   <= StTone;
            active_q  <= req_q;
            tone_on_q <= 1'b1;
          end
        end
        StTone: begin
          if (req_q != active_q) state_q <= StPend;
        end
        StPend: begin
          // A return to the sounding note cancels the change untouched.
          if (req_q == active_q) begin
            state_q <= StTone;
          end else if (div_fall) begin
            if (!is_tone(req_q)) begin
              state_q   <= StIdle;
              active_q  <= NoteRest;
              tone_on_q <= 1'b0;
            end else begin
`ifdef PIEZO_TONE_GAP_EN
              state_q   <= StGap;
              active_q  <= NoteRest;
              tone_on_q <= 1'b0;
              gap_cnt_q <= '0;
`else
              state_q   <= StTone;
              active_q  <= req_q;
`endif
            end
          end
        end
`ifdef PIEZO_TONE_GAP_EN
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            if (is_tone(req_q)) begin
              state_q   <= StTone;
              active_q  <= req_q;
              tone_on_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign active_note = active_q;
  assign tone_on     = tone_on_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Self-checking bench for piezo_tone_gen: directed scenarios plus random
// note sequences, all compared cycle by cycle against a waveform model.
module tb_piezo_tone_gen;

  localparam int unsigned ClkHz     = 100_000;
  localparam int unsigned GapMs     = 1;
  localparam int          GapCycles = ClkHz / 1000 * GapMs;
`ifdef PIEZO_TONE_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] note_code = 4'd0;
  logic       piezo;
  logic [3:0] active_note;
  logic       tone_on;

  int n_checks = 0;
  int n_errors = 0;

  piezo_tone_gen #(
    .CLK_HZ (ClkHz),
    .GAP_MS (GapMs)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .note_code   (note_code),
    .piezo       (piezo),
    .active_note (active_note),
    .tone_on     (tone_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Equal-tempered pitches of C4..C5.
  function automatic real freq_of(int n);
    case (n)
      1:       return 261.626;
      2:       return 293.665;
      3:       return 329.628;
      4:       return 349.228;
      5:       return 391.995;
      6:       return 440.000;
      7:       return 493.883;
      8:       return 523.251;
      default: return 0.0;
    endcase
  endfunction

  function automatic int half_of(int n);
    if (n < 1 || n > 8) return 0;
    return $rtoi(real'(ClkHz) / (2.0 * freq_of(n)) + 0.5);
  endfunction

  function automatic bit is_note(int c);
    return c >= 1 && c <= 8;
  endfunction

  // Model: the sounding note, cycles since it started, and the gap left.
  int m_req, m_prev, m_note, m_t, m_gap;
  int hi_len, hi_note;

  task automatic model_reset();
    m_req = 0; m_prev = 0; m_note = 0; m_t = 0; m_gap = 0;
  endtask

  // One clock edge. A change takes effect at a falling edge only once the
  // request has already differed from the sounding note for a cycle.
  task automatic model_edge(input int nc);
    int r;
    r = m_req;
    if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        if (is_note(r)) begin m_note = r; m_t = 0; end
      end else begin
        m_gap--;
      end
    end else if (m_note == 0) begin
      if (is_note(r)) begin m_note = r; m_t = 0; end
    end else begin
      m_t++;
      if ((m_t % (2 * half_of(m_note))) == 0 && r != m_note && m_prev != m_note) begin
        if (!is_note(r)) begin
          m_note = 0;
        end else if (GapEn) begin
          m_note = 0;
          m_gap  = GapCycles;
        end else begin
          m_note = r;
          m_t    = 0;
        end
      end
    end
    m_prev = r;
    m_req  = nc;
  endtask

  function automatic int exp_piezo();
    if (m_note == 0) return 0;
    return (m_t / half_of(m_note)) % 2;
  endfunction

  task automatic compare();
    check("piezo", int'(piezo), exp_piezo());
    check("tone_on", int'(tone_on), (m_note != 0) ? 1 : 0);
    check("active_note", int'(active_note), m_note);
    if (piezo === 1'b1) begin
      hi_len++;
      hi_note = m_note;
    end else if (hi_len > 0) begin
      check("high_len", hi_len, half_of(hi_note));
      hi_len = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(int'(note_code));
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the model is `into` cycles into a high half of `note`.
  task automatic run_to_high(input int note, input int into);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (m_note == note && (m_t % (2 * half_of(note))) == half_of(note) + into) break;
      step();
    end
    if (k == 2000) check("reach_high_timeout", 0, 1);
  endtask

  // Assert reset between edges; outputs must drop without a clock.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    hi_len = 0;
    check("async_piezo", int'(piezo), 0);
    check("async_tone_on", int'(tone_on), 0);
    check("async_active", int'(active_note), 0);
    run(3);
    reset = 1'b1;
  endtask

  initial begin
    int low_cnt;
    int k;
    model_reset();
    hi_len = 0; hi_note = 0;

    // Reset held with a note requested: silence throughout.
    note_code = 4'd6;
    run(5);

    // Release: A4 starts two cycles later, full periods checked.
    reset = 1'b1;
    run(2);
    check("a4_tone_on_2cyc", int'(tone_on), 1);
    run(400);

    // C4 requested mid-high: A4 finishes its high half first.
    run_to_high(6, 20);
    note_code = 4'd1;
    run(800);

    // Code 12 is a rest.
    note_code = 4'd12;
    run(450);
    check("rest12_active", int'(active_note), 0);

    // Short excursion to E4 inside the high half leaves A4 undisturbed.
    note_code = 4'd6;
    run(300);
    run_to_high(6, 10);
    note_code = 4'd3;
    run(10);
    note_code = 4'd6;
    run(400);

    // Tone-to-tone switch 1 -> 8: silent cycles only with the gap feature.
    note_code = 4'd1;
    run(1000);
    note_code = 4'd8;
    low_cnt = 0;
    for (k = 0; k < 3000; k++) begin
      step();
      if (tone_on === 1'b0) low_cnt++;
      if (active_note === 4'd8) break;
    end
    check("switch_done", (k < 3000) ? 1 : 0, 1);
    check("switch_silent_cycles", low_cnt, GapEn ? GapCycles : 0);
    run(400);

    async_reset();
    run(300);

    // Random note sequences with occasional short pulses and resets.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 3) == 0) note_code = 4'($urandom_range(0, 15));
      else note_code = 4'($urandom_range(1, 8));
      if ($urandom_range(0, 4) == 0) run($urandom_range(1, 12));
      else run($urandom_range(20, 500));
      if ($urandom_range(0, 14) == 0) async_reset();
    end
    note_code = 4'd0;
    run(500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
